// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    localparam logic [5:0] NO_KEY   = 6'h3F;
    localparam logic [3:0] COL_IDLE = 4'b1111;
    localparam logic [3:0] COL_0    = 4'b1110;
    localparam logic [3:0] COL_1    = 4'b1101;
    localparam logic [3:0] COL_2    = 4'b1011;
    localparam logic [3:0] COL_3    = 4'b0111;

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        case (col)
            2'd0:    col_drive = COL_0;
            2'd1:    col_drive = COL_1;
            2'd2:    col_drive = COL_2;
            default: col_drive = COL_3;
        endcase
    endfunction

    // Rows are active-low; the lowest-numbered active row wins.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        casez (rows)
            4'b???0: low_row = 2'd0;
            4'b??01: low_row = 2'd1;
            4'b?011: low_row = 2'd2;
            default: low_row = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side and consumer-side signals of the scanner.
// Levels only, no handshake: key_press is high while indice_boton holds a confirmed key.
interface keypad_scan_if;
    logic       enable;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [5:0] indice_boton;
    logic       key_press;

    modport master (
        input  enable,
        input  filas,
        output columnas,
        output indice_boton,
        output key_press
    );

    modport slave (
        output enable,
        output filas,
        input  columnas,
        input  indice_boton,
        input  key_press
    );
endinterface

// File: rtl/kp_sync2.sv
// Two-flop synchronizer; resets to all ones so idle (pulled-up) rows look released.
module kp_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce; reports one held key at a time.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV         = 1000,
    parameter int DEBOUNCE_SAMPLES = 8
) (
    input  logic           clk,
    input  logic           reset,
    keypad_scan_if.master  kp,
    output kp_state_t      state_o
);
    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int DEBW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
    localparam logic [DEBW-1:0] DEB_TOP  = DEBW'(DEBOUNCE_SAMPLES - 1);

    logic [3:0]      rows_s;
    kp_state_t       state_q;
    logic [DIVW-1:0] div_q;
    logic [DEBW-1:0] deb_q;
    logic [DEBW-1:0] rel_q;
    logic [1:0]      col_q;
    logic [3:0]      cand_q;
    logic [3:0]      columnas_q;
    logic [5:0]      idx_q;
    logic            kp_q;

    logic       sample;
    logic       any_row;
    logic [1:0] hit_row;

    kp_sync2 #(.W(4)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (kp.filas),
        .q_o   (rows_s)
    );

    assign sample  = (div_q == DIV_LAST);
    assign any_row = (rows_s != 4'hF);
    assign hit_row = low_row(rows_s);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SCAN;
            div_q      <= '0;
            deb_q      <= '0;
            rel_q      <= '0;
            col_q      <= 2'd0;
            cand_q     <= 4'd0;
            columnas_q <= COL_0;
            idx_q      <= NO_KEY;
            kp_q       <= 1'b0;
        end else if (!kp.enable) begin
            state_q    <= SCAN;
            div_q      <= '0;
            deb_q      <= '0;
            rel_q      <= '0;
            col_q      <= 2'd0;
            cand_q     <= 4'd0;
            columnas_q <= COL_IDLE;
            idx_q      <= NO_KEY;
            kp_q       <= 1'b0;
        end else begin
            div_q <= sample ? '0 : div_q + 1'b1;
            // First enabled cycle after a drop: drive column 0 again.
            if (columnas_q == COL_IDLE) begin
                columnas_q <= COL_0;
            end
            if (sample) begin
                case (state_q)
                    SCAN: begin
                        if (!any_row) begin
                            col_q      <= col_q + 2'd1;
                            columnas_q <= col_drive(col_q + 2'd1);
                        end else begin
                            cand_q  <= {hit_row, col_q};
                            deb_q   <= '0;
                            state_q <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (any_row && hit_row == cand_q[3:2]) begin
                            if (deb_q == DEB_TOP) begin
                                state_q <= HELD;
                                idx_q   <= {2'b00, cand_q};
                                kp_q    <= 1'b1;
                                deb_q   <= '0;
                                rel_q   <= '0;
                            end else begin
                                deb_q <= deb_q + 1'b1;
                            end
                        end else begin
                            deb_q      <= '0;
                            state_q    <= SCAN;
                            col_q      <= col_q + 2'd1;
                            columnas_q <= col_drive(col_q + 2'd1);
                        end
                    end
                    HELD: begin
                        // Only the candidate row matters; other keys are ignored.
                        if (rows_s[cand_q[3:2]]) begin
                            if (rel_q == DEB_TOP) begin
                                state_q <= SCAN;
                                kp_q    <= 1'b0;
                                idx_q   <= NO_KEY;
                                rel_q   <= '0;
                            end else begin
                                rel_q <= rel_q + 1'b1;
                            end
                        end else begin
                            rel_q <= '0;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign kp.columnas     = columnas_q;
    assign kp.indice_boton = idx_q;
    assign kp.key_press    = kp_q;
    assign state_o         = state_q;
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans the 4x4 matrix keypad, debounces it and reports one stable key at a time. It sits directly upstream of the edge-detect/sync stage and the key translator. It drives the keypad columns, samples the rows, and outputs a 0–15 button index plus a level `key_press` that stays high while the key is confirmed held.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per column slot; must be ≥ 4.
- `DEBOUNCE_SAMPLES`, default 8: consecutive matching samples needed to confirm a press or a release; must be ≥ 1.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  scan enable; low forces idle synchronously.
- `filas`  in  4  keypad rows, active-low (pulled up), asynchronous to `clk`.
- `columnas`  out  4  column drive, one-hot active-low; 4'b1111 = none driven.
- `indice_boton`  out  6  confirmed key, `row*4+col` (0–15); 6'h3F = no key.
- `key_press`  out  1  high while a confirmed key is held.

## Operation
- `filas` passes through a two-flop synchronizer. All decisions use the synchronized value `rows_s`.
- Slot counter `div` runs 0..SCAN_DIV-1. The sample point is `div == SCAN_DIV-1`; rows are evaluated only there.
- States:
  - **SCAN**: at each sample point, if `rows_s == 4'hF`, rotate the column 0→1→2→3→0 (`columnas` 1110→1101→1011→0111). Otherwise latch `cand = row*4+col`, taking the lowest-index active row. Hold the column, clear `deb`, go to DEBOUNCE.
  - **DEBOUNCE**: at each sample point, if the active-row pattern still selects `cand`, increment `deb`. When `deb` reaches DEBOUNCE_SAMPLES, go to HELD and set `indice_boton = cand` and `key_press = 1`. On any mismatch, clear `deb`, go to SCAN and advance the column.
  - **HELD**: the column stays frozen. Keys in other columns are ignored. A sample with the `cand` row inactive increments `deb_rel`; a sample with it active clears `deb_rel`. When `deb_rel` reaches DEBOUNCE_SAMPLES, go to SCAN with `key_press = 0` and `indice_boton = 6'h3F`.
- Multiple keys in the same column at first detection: the lowest row wins. Adding a key while in HELD does not change `indice_boton`.
- `enable` low on any cycle: next cycle gives state SCAN, `columnas = 4'b1111`, `key_press = 0`, `indice_boton = 6'h3F`, and all counters cleared. When `enable` rises, scanning restarts at column 0 with `div = 0`.
- Counter widths are `$clog2` of their parameter. They never wrap past their terminal value.

## Timing
- Reset values: state SCAN, `columnas = 4'b1110`, `indice_boton = 6'h3F`, `key_press = 0`, `div`, `deb`, `deb_rel` = 0, synchronizer flops = 4'hF.
- All outputs are registered; there is no combinational path from `filas` to any output.
- Synchronizer latency is 2 cycles.
- Press confirm: `key_press` rises 1 cycle after the DEBOUNCE_SAMPLES-th matching sample point. Ideal minimum from detection is DEBOUNCE_SAMPLES×SCAN_DIV + 1 cycles.
- `indice_boton` and `key_press` change on the same edge. `indice_boton` is stable for the whole time `key_press` is high.
- Release confirm uses the same latency, measured from the first inactive sample.
- A column change on `columnas` is never sampled in the same slot: the first sample after a change is SCAN_DIV cycles later, which covers synchronizer delay and settling.
- Reset mid-operation (any state) returns to reset values immediately, asynchronously.

## Structure
- Package `keypad_pkg` holds:
  - the state enum (SCAN, DEBOUNCE, HELD);
  - `NO_KEY = 6'h3F`;
  - `COL_IDLE = 4'b1111`;
  - the column one-hot constants.
- Sub-module `kp_sync2`: a parameterized-width two-flop synchronizer with async active-low reset and a reset value of all ones.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SAMPLES=3.
- **Reset:** hold `reset=0` with `filas` toggling. Require `columnas=1110`, `indice_boton=3F`, `key_press=0`. After release, `columnas` rotates every 4 cycles.
- **Clean press:** drive row 2 low only while column 1 is driven, held 200 cycles. Require `key_press=1` and `indice_boton=9` within 3×4+4 cycles of first detection. After release, `key_press=0` and `indice_boton=3F` after 3 inactive samples.
- **Bounce:** toggle row 0 on column 3 with a 6-cycle period, shorter than 3 samples. Require `key_press` never rises and scanning resumes.
- **Multi-key:** rows 1 and 3 active on column 0 at once. Require `indice_boton=4`. Then press row 0 on column 2 while held; `indice_boton` stays 4.
- **Enable drop:** deassert `enable` while in HELD. Next cycle require `key_press=0`, `indice_boton=3F`, `columnas=1111`. After re-enable, `columnas=1110` restarts.
- **Reset mid-debounce:** assert `reset` after 2 matching samples. Require reset values at once, and no `key_press` pulse after release until a full 3-sample confirm.
